// File: rtl/ibex_mem_responder.sv
// Memory-side responder for the Ibex req/gnt/rvalid bus with inverted SECDED(39,32) integrity.
// Grants every unstalled request and returns in-order responses after a fixed latency.
module ibex_mem_responder #(
  parameter int unsigned Depth     = 1024,
  parameter logic [31:0] BaseAddr  = 32'h0010_0000,
  parameter int unsigned Latency   = 1,
  parameter bit          IntgCheck = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [6:0]  wdata_intg_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic [6:0]  rdata_intg_o,
  output logic        err_o,
  output logic        intg_alert_o,
  output logic [15:0] err_count_o
);

  localparam int unsigned IdxW   = $clog2(Depth);
  localparam logic [29:0] DepthW = 30'(Depth);

  function automatic logic [6:0] secded_inv_enc(input logic [31:0] d);
    logic [6:0] c;
    c[0] = ^(d & 32'h2606BD25);
    c[1] = ^(d & 32'hDEBA8050);
    c[2] = ^(d & 32'h413D89AA);
    c[3] = ^(d & 32'h31234ED1);
    c[4] = ^(d & 32'hC2C1323B);
    c[5] = ^(d & 32'h2DCC624C);
    c[6] = ^(d & 32'h98505586);
    return c ^ 7'h2A;
  endfunction

  logic [31:0]     mem [Depth];
  logic [29:0]     word_off;
  logic [IdxW-1:0] idx;
  logic            in_range;
  logic            intg_ok;
  logic            do_write;
  logic            bad_intg;
  logic [31:0]     resp_rdata;
  logic            resp_err;
  logic            unused_addr;

  logic [Latency-1:0] valid_q;
  logic [Latency-1:0] err_q;
  logic [31:0]        data_q [Latency];
  logic               alert_q;
  logic [15:0]        count_q;

  assign gnt_o       = req_i & ~stall_i & rst_ni;
  assign unused_addr = ^addr_i[1:0];

  // Unsigned offset from the base: addresses below BaseAddr wrap high and fall out of range.
  assign word_off   = addr_i[31:2] - BaseAddr[31:2];
  assign idx        = word_off[IdxW-1:0];
  assign in_range   = word_off < DepthW;
  assign intg_ok    = !IntgCheck || (secded_inv_enc(wdata_i) == wdata_intg_i);
  assign do_write   = gnt_o & we_i & in_range & intg_ok;
  assign bad_intg   = gnt_o & we_i & ~intg_ok;
  assign resp_rdata = (gnt_o && !we_i && in_range) ? mem[idx] : '0;
  assign resp_err   = ~in_range | (we_i & ~intg_ok);

  always_ff @(posedge clk_i) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem[idx][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= '0;
      err_q   <= '0;
      alert_q <= 1'b0;
      for (int i = 0; i < Latency; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= gnt_o;
      err_q[0]   <= gnt_o & resp_err;
      data_q[0]  <= resp_rdata;
      alert_q    <= bad_intg;
      for (int i = 1; i < Latency; i++) begin
        valid_q[i] <= valid_q[i-1];
        err_q[i]   <= err_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  // Registered outputs are also masked by rst_ni so a response due in the reset cycle is dropped.
  assign rvalid_o     = valid_q[Latency-1] & rst_ni;
  assign err_o        = err_q[Latency-1] & rst_ni;
  assign rdata_o      = rst_ni ? data_q[Latency-1] : '0;
  assign rdata_intg_o = secded_inv_enc(rdata_o);
  assign intg_alert_o = alert_q & rst_ni;
  assign err_count_o  = rst_ni ? count_q : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (rvalid_o && err_o && count_q != 16'hFFFF) begin
      count_q <= count_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_ibex_mem_responder.sv
// Scoreboard bench for ibex_mem_responder: driver pushes expected responses from a
// behavioural memory model, a negedge monitor pops and compares them as rvalid appears.
module tb_ibex_mem_responder;

  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0010_0000;
  localparam int unsigned LAT   = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        stall_i;
  logic        req_i;
  logic        gnt_o;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [6:0]  wdata_intg_i;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic [6:0]  rdata_intg_o;
  logic        err_o;
  logic        intg_alert_o;
  logic [15:0] err_count_o;

  typedef struct {
    int          due;
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  resp_t       exp_q[$];
  int          alert_q[$];
  logic [31:0] ref_mem [DEPTH];
  logic [15:0] err_cnt_model = '0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  ibex_mem_responder #(
    .Depth(DEPTH), .BaseAddr(BASE), .Latency(LAT), .IntgCheck(1'b1)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .stall_i(stall_i), .req_i(req_i), .gnt_o(gnt_o),
    .we_i(we_i), .be_i(be_i), .addr_i(addr_i), .wdata_i(wdata_i), .wdata_intg_i(wdata_intg_i),
    .rvalid_o(rvalid_o), .rdata_o(rdata_o), .rdata_intg_o(rdata_intg_o), .err_o(err_o),
    .intg_alert_o(intg_alert_o), .err_count_o(err_count_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Each check bit is the parity of the data bits selected by its column mask, then inverted per 7'h2A.
  function automatic logic [6:0] ref_enc(input logic [31:0] d);
    logic [31:0] masks [7];
    logic [6:0]  inv;
    logic [6:0]  c;
    masks = '{32'h2606BD25, 32'hDEBA8050, 32'h413D89AA, 32'h31234ED1,
              32'hC2C1323B, 32'h2DCC624C, 32'h98505586};
    inv = 7'h2A;
    for (int j = 0; j < 7; j++) begin
      c[j] = inv[j];
      for (int i = 0; i < 32; i++) begin
        if (masks[j][i]) c[j] = c[j] ^ d[i];
      end
    end
    return c;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic stall, input logic req, input logic we,
                               input logic [3:0] be, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [6:0] flip);
    logic        exp_gnt;
    logic        in_rng;
    logic        ok;
    logic [29:0] word;
    resp_t       e;
    @(posedge clk_i);
    #1;
    rst_ni       = rst;
    stall_i      = stall;
    req_i        = req;
    we_i         = we;
    be_i         = be;
    addr_i       = addr;
    wdata_i      = wdata;
    wdata_intg_i = ref_enc(wdata) ^ flip;
    #1;
    exp_gnt = req & ~stall & rst;
    checkOutput("gnt", {31'b0, gnt_o}, {31'b0, exp_gnt});
    if (!rst) begin
      exp_q.delete();
      alert_q.delete();
      err_cnt_model = '0;
    end
    if (exp_gnt) begin
      word    = addr[31:2] - BASE[31:2];
      in_rng  = (word < 30'(DEPTH));
      ok      = (flip == 7'h00);
      e.due   = cyc + int'(LAT);
      e.err   = !in_rng || (we && !ok);
      e.rdata = '0;
      if (we && !ok) alert_q.push_back(cyc + 1);
      if (we && in_rng && ok) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) ref_mem[int'(word)][8*b +: 8] = wdata[8*b +: 8];
        end
      end
      if (!we && in_rng) e.rdata = ref_mem[int'(word)];
      exp_q.push_back(e);
    end
  endtask

  task automatic idle();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 7'h00);
  endtask

  task automatic rd(input logic [31:0] addr);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, addr, 32'h0, 7'h00);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be,
                    input logic [6:0] flip);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, be, addr, data, flip);
  endtask

  // Monitor: alert and error count every cycle, responses whenever rvalid is seen.
  always @(negedge clk_i) begin
    resp_t e;
    logic  exp_alert;
    checkOutput("err_count", {16'b0, err_count_o}, {16'b0, err_cnt_model});
    exp_alert = (alert_q.size() > 0 && alert_q[0] == cyc);
    if (exp_alert) void'(alert_q.pop_front());
    checkOutput("intg_alert", {31'b0, intg_alert_o}, {31'b0, exp_alert});
    if (rvalid_o !== 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_rvalid: got rvalid=%b expected 0 (cycle %0d)", rvalid_o, cyc);
      end else begin
        e = exp_q.pop_front();
        checkOutput("resp_cycle", 32'(cyc), 32'(e.due));
        checkOutput("rdata", rdata_o, e.rdata);
        checkOutput("err", {31'b0, err_o}, {31'b0, e.err});
        checkOutput("rdata_intg", {25'b0, rdata_intg_o}, {25'b0, ref_enc(e.rdata)});
        if (e.err) err_cnt_model = err_cnt_model + 16'd1;
      end
    end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL missing_rvalid: got rvalid=0 expected 1 (due cycle %0d)", e.due);
    end
  end

  initial begin
    logic [31:0] a;
    logic [6:0]  f;
    rst_ni = 1'b0; stall_i = 1'b0; req_i = 1'b0; we_i = 1'b0;
    be_i = 4'h0; addr_i = '0; wdata_i = '0; wdata_intg_i = 7'h2A;

    // Reset holds everything quiet even with a request pending.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, BASE, 32'h0, 7'h00);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, BASE, 32'h0, 7'h00);
    @(negedge clk_i);
    checkOutput("reset_rvalid", {31'b0, rvalid_o}, 32'h0);
    checkOutput("reset_rdata", rdata_o, 32'h0);
    checkOutput("reset_rdata_intg", {25'b0, rdata_intg_o}, 32'h2A);
    checkOutput("reset_err", {31'b0, err_o}, 32'h0);

    for (int w = 0; w < DEPTH; w++) wr(BASE + 32'(4 * w), 32'(w + 1), 4'hF, 7'h00);

    wr(BASE + 32'h10, 32'hDEADBEEF, 4'hF, 7'h00);
    rd(BASE + 32'h10);
    wr(BASE + 32'h10, 32'h0000AA00, 4'b0010, 7'h00);
    rd(BASE + 32'h10);
    rd(BASE + 32'(4 * DEPTH));
    rd(BASE - 32'h4);
    wr(BASE + 32'h10, 32'h12345678, 4'hF, 7'h01);
    rd(BASE + 32'h10);
    wr(BASE + 32'h14, 32'hFFFFFFFF, 4'h0, 7'h00);
    rd(BASE + 32'h14);

    repeat (3) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, BASE, 32'h0, 7'h00);
    for (int w = 0; w < 4; w++) rd(BASE + 32'(4 * w));
    repeat (LAT + 1) idle();

    rd(BASE);
    rd(BASE + 32'h4);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 7'h00);
    repeat (LAT + 2) idle();
    rd(BASE);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) < 90)
        a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
      else if ($urandom_range(0, 1) == 0)
        a = BASE - 32'(4 * $urandom_range(1, 1000));
      else
        a = BASE + 32'(4 * $urandom_range(DEPTH, DEPTH + 1000));
      f = ($urandom_range(0, 9) == 0) ? (7'h01 << $urandom_range(0, 6)) : 7'h00;
      applyStimulus(($urandom_range(0, 99) != 0), ($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 15)), a, $urandom, f);
    end

    repeat (LAT + 3) idle();
    checkOutput("drain_empty", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
